// File: rtl/expand_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | expand_stream_if                                                           |
// | Bundles the coefficient input stream and the multi-bank write port of the |
// | expand_stream loader.                                                      |
// |   slave  : loader view (consumes the stream, drives the bank writes)       |
// |   master : environment view (drives the stream, accepts the bank writes)   |
// | Signals: start, mode, in_valid/in_ready, in_addr, in_data, wr_en, wr_addr, |
// |          wr_data, wr_ready, busy, done.                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

interface expand_stream_if #(
    parameter int LOGN      = 13,
    parameter int NUM_BANKS = 2,
    parameter int W         = 2 * `OVERALL_BITS
);
    localparam int LOGB = $clog2(NUM_BANKS);
    localparam int AW   = LOGN - LOGB;

    logic                    start;
    logic                    mode;
    logic                    in_valid;
    logic                    in_ready;
    logic [LOGN-1:0]         in_addr;
    logic [W-1:0]            in_data;
    logic [NUM_BANKS-1:0]    wr_en;
    logic [NUM_BANKS*AW-1:0] wr_addr;
    logic [NUM_BANKS*W-1:0]  wr_data;
    logic                    wr_ready;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, mode, in_valid, in_addr, in_data, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport master (
        output start, mode, in_valid, in_addr, in_data, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/expand_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | expand_stream                                                              |
// | Coefficient loader between the software input stream and the FFT BRAM     |
// | banks. Direct mode writes each addressed word to bank addr mod NUM_BANKS;  |
// | expand mode walks the rotation-group slot order (pos <- 3*pos mod 2N) and  |
// | writes every word plus its conjugate to two complementary banks.           |
// | Ports: clk, rst_n (sync, active-low), bus (expand_stream_if.slave).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

module expand_stream #(
    parameter int LOGN      = 13,
    parameter int NUM_BANKS = 2,
    parameter int W         = 2 * `OVERALL_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    expand_stream_if.slave bus
);
    localparam int LOGB     = $clog2(NUM_BANKS);
    localparam int AW       = LOGN - LOGB;
    localparam int HALF_N   = 1 << (LOGN - 1);
    localparam int SIGN_BIT = W / 2 - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic [LOGN:0]           pos_q;
    logic [LOGN-1:0]         cnt_q;
    logic [NUM_BANKS-1:0]    wr_en_q;
    logic [NUM_BANKS*AW-1:0] wr_addr_q;
    logic [NUM_BANKS*W-1:0]  wr_data_q;
    logic                    done_q;

    logic [NUM_BANKS-1:0]    wr_en_d;
    logic [NUM_BANKS*AW-1:0] wr_addr_d;
    logic [NUM_BANKS*W-1:0]  wr_data_d;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int k = 0; k < LOGN; k++) begin
            r[k] = x[LOGN-1-k];
        end
        return r;
    endfunction

    // The output stage is occupied whenever any lane is enabled.
    logic out_valid, out_free, in_ready, accept;
    assign out_valid = |wr_en_q;
    assign out_free  = !out_valid || bus.wr_ready;
    assign in_ready  = ((state_q == S_RUN) || ((state_q == S_IDLE) && !bus.mode)) && out_free;
    assign accept    = bus.in_valid && in_ready;

    // Slot pair for the current rotation position. M-1-pos is simply ~pos
    // in LOGN+1 bits, so the second slot is always the bitwise complement of
    // the first and the two banks can never collide.
    logic [LOGN-1:0] a0, a1, i0, i1;
    logic [LOGB-1:0] bank0, bank1, dir_bank;
    logic [AW-1:0]   addr0, addr1, dir_addr;
    logic [W-1:0]    conj_data;

    assign a0        = LOGN'((pos_q - (LOGN+1)'(1)) >> 1);
    assign a1        = LOGN'((~pos_q) >> 1);
    assign i0        = bitrev(a0);
    assign i1        = bitrev(a1);
    assign bank0     = i0[LOGB-1:0];
    assign bank1     = i1[LOGB-1:0];
    assign addr0     = i0[LOGN-1:LOGB];
    assign addr1     = i1[LOGN-1:LOGB];
    assign dir_bank  = bus.in_addr[LOGB-1:0];
    assign dir_addr  = bus.in_addr[LOGN-1:LOGB];
    assign conj_data = bus.in_data ^ (W'(1) << SIGN_BIT);

    // Candidate lane contents for the word currently offered on the input.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q == S_RUN) begin
                if (LOGB'(b) == bank0) begin
                    wr_en_d[b]           = 1'b1;
                    wr_addr_d[b*AW +: AW] = addr0;
                    wr_data_d[b*W +: W]   = bus.in_data;
                end else if (LOGB'(b) == bank1) begin
                    wr_en_d[b]           = 1'b1;
                    wr_addr_d[b*AW +: AW] = addr1;
                    wr_data_d[b*W +: W]   = conj_data;
                end
            end else if (LOGB'(b) == dir_bank) begin
                wr_en_d[b]           = 1'b1;
                wr_addr_d[b*AW +: AW] = dir_addr;
                wr_data_d[b*W +: W]   = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pos_q     <= (LOGN+1)'(1);
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Output stage: hold while stalled, otherwise load or empty.
            if (out_free) begin
                if (accept) begin
                    wr_en_q   <= wr_en_d;
                    wr_addr_q <= wr_addr_d;
                    wr_data_q <= wr_data_d;
                end else begin
                    wr_en_q   <= '0;
                    wr_addr_q <= '0;
                    wr_data_q <= '0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start && bus.mode) begin
                        state_q <= S_RUN;
                        pos_q   <= (LOGN+1)'(1);
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pos_q <= pos_q + {pos_q[LOGN-1:0], 1'b0};
                        cnt_q <= cnt_q + LOGN'(1);
                        if (cnt_q == LOGN'(HALF_N - 1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!out_valid) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;

    a_conj_pair : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_RUN) |-> ((i1 == ~i0) && (bank0 != bank1)));

endmodule

`default_nettype wire

// File: tb/tb_expand_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_expand_stream                                                           |
// | Self-checking bench: two loaders (LOGN=3, 2 banks and 4 banks) share one   |
// | stimulus; a slot-level reference model and a literal vector table define  |
// | the expected bank writes.                                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module tb_expand_stream;
    localparam int LOGN = 3;
    localparam int N    = 8;
    localparam int M    = 16;
    localparam int W    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, in_valid, wr_ready;
    logic [2:0]  in_addr;
    logic [15:0] in_data;

    expand_stream_if #(.LOGN(LOGN), .NUM_BANKS(2), .W(W)) if2 ();
    expand_stream_if #(.LOGN(LOGN), .NUM_BANKS(4), .W(W)) if4 ();

    assign if2.start = start;    assign if4.start = start;
    assign if2.mode = mode;      assign if4.mode = mode;
    assign if2.in_valid = in_valid; assign if4.in_valid = in_valid;
    assign if2.in_addr = in_addr;   assign if4.in_addr = in_addr;
    assign if2.in_data = in_data;   assign if4.in_data = in_data;
    assign if2.wr_ready = wr_ready; assign if4.wr_ready = wr_ready;

    expand_stream #(.LOGN(LOGN), .NUM_BANKS(2), .W(W)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    expand_stream #(.LOGN(LOGN), .NUM_BANKS(4), .W(W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (slot arithmetic) ----------------
    int  m_phase;   // 0 idle, 1 run, 2 drain
    int  m_pos, m_cnt;
    bit  m_ov, m_done;
    logic [1:0]  e2_en;  logic [3:0] e2_addr; logic [31:0] e2_data;
    logic [3:0]  e4_en;  logic [3:0] e4_addr; logic [63:0] e4_data;
    bit  chk_on = 1'b0;
    bit  last_acc;
    int  n_acc_obs = 0, n_done_obs = 0, n_ret_obs = 0;

    function automatic int bitrev3(int x);
        int r = 0;
        for (int k = 0; k < 3; k++) if (((x >> k) & 1) != 0) r = r | (1 << (2 - k));
        return r;
    endfunction

    function automatic bit m_ready();
        return ((m_phase == 1) || (m_phase == 0 && !mode)) && (!m_ov || wr_ready);
    endfunction

    task automatic clear_exp();
        e2_en = '0; e2_addr = '0; e2_data = '0;
        e4_en = '0; e4_addr = '0; e4_data = '0;
    endtask

    task automatic put_slot(int s, logic [15:0] d);
        e2_en[s % 2] = 1'b1;
        e2_addr[(s % 2) * 2 +: 2] = 2'(s / 2);
        e2_data[(s % 2) * 16 +: 16] = d;
        e4_en[s % 4] = 1'b1;
        e4_addr[s % 4] = 1'(s / 4);
        e4_data[(s % 4) * 16 +: 16] = d;
    endtask

    task automatic model_edge(bit acc);
        bit ov_pre;
        int s0, s1;
        ov_pre = m_ov;
        if (!rst_n) begin
            m_phase = 0; m_pos = 1; m_cnt = 0; m_ov = 0; m_done = 0;
            clear_exp();
            return;
        end
        m_done = 0;
        if (!m_ov || wr_ready) begin
            clear_exp();
            m_ov = 0;
            if (acc) begin
                if (m_phase == 1) begin
                    s0 = bitrev3((m_pos - 1) / 2);
                    s1 = bitrev3((M - 1 - m_pos) / 2);
                    put_slot(s0, in_data);
                    put_slot(s1, in_data ^ 16'h0080);
                end else begin
                    put_slot(int'(in_addr), in_data);
                end
                m_ov = 1;
            end
        end
        case (m_phase)
            0: if (start && mode) begin m_phase = 1; m_pos = 1; m_cnt = 0; end
            1: if (acc) begin
                   m_pos = (3 * m_pos) % M;
                   m_cnt++;
                   if (m_cnt == N / 2) m_phase = 2;
               end
            default: if (!ov_pre) begin m_phase = 0; m_done = 1; end
        endcase
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 ns
    // after the rising edge so the caller can drive the next inputs.
    task automatic step();
        @(negedge clk);
        if (chk_on) begin
            chk("in_ready2", 64'(if2.in_ready), 64'(m_ready()));
            chk("in_ready4", 64'(if4.in_ready), 64'(m_ready()));
            chk("wr_en2",    64'(if2.wr_en),    64'(e2_en));
            chk("wr_en4",    64'(if4.wr_en),    64'(e4_en));
            chk("wr_addr2",  64'(if2.wr_addr),  64'(e2_addr));
            chk("wr_addr4",  64'(if4.wr_addr),  64'(e4_addr));
            chk("wr_data2",  64'(if2.wr_data),  64'(e2_data));
            chk("wr_data4",  64'(if4.wr_data),  e4_data);
            chk("busy2",     64'(if2.busy),     64'(m_phase != 0));
            chk("busy4",     64'(if4.busy),     64'(m_phase != 0));
            chk("done2",     64'(if2.done),     64'(m_done));
            chk("done4",     64'(if4.done),     64'(m_done));
        end
        if (rst_n && in_valid && if2.in_ready) n_acc_obs++;
        if (rst_n && if2.done) n_done_obs++;
        if (rst_n && (|if2.wr_en) && wr_ready) n_ret_obs++;
        last_acc = in_valid && m_ready();
        model_edge(last_acc);
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass();
        mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(logic [15:0] d);
        bit got = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = last_acc;
        end
        in_valid = 1'b0;
        chk("push_accepted", 64'(got), 64'(1));
    endtask

    task automatic drain();
        bit found = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            step();
            found = if2.done;
        end
        chk("done_within_budget", 64'(found), 64'(1));
        step();
    endtask

    function automatic logic [63:0] lanes(int nb, logic [3:0] en, logic [3:0] cj, logic [15:0] d);
        logic [63:0] r = '0;
        for (int b = 0; b < nb; b++)
            if (en[b]) r[b*16 +: 16] = cj[b] ? (d ^ 16'h0080) : d;
        return r;
    endfunction

    typedef struct {
        logic [15:0] d;
        logic [1:0]  en2; logic [3:0] addr2; logic [3:0] cj2;
        logic [3:0]  en4; logic [3:0] addr4; logic [3:0] cj4;
    } vec_t;
    vec_t tbl [4];

    logic [1:0]  snap_en;
    logic [3:0]  snap_addr;
    logic [31:0] snap_data;
    int a_base, d_base, r_base;

    initial begin
        // Slot pairs (0,7),(4,3),(1,6),(5,2): bank0 addr 0,2,3,1 / bank1 addr 3,1,0,2
        // and for 4 banks (0,3),(0,3),(1,2),(1,2) with one address bit per lane.
        tbl[0] = '{16'h1234, 2'b11, 4'b1100, 4'b0010, 4'b1001, 4'b1000, 4'b1000};
        tbl[1] = '{16'h5678, 2'b11, 4'b0110, 4'b0010, 4'b1001, 4'b0001, 4'b1000};
        tbl[2] = '{16'h9ABC, 2'b11, 4'b0011, 4'b0001, 4'b0110, 4'b0100, 4'b0100};
        tbl[3] = '{16'hDEF0, 2'b11, 4'b1001, 4'b0001, 4'b0110, 4'b0010, 4'b0100};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_data = '0; wr_ready = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        chk("rst_wr_en2", 64'(if2.wr_en), 64'(0));
        chk("rst_wr_data4", if4.wr_data, 64'(0));
        chk("rst_in_ready_direct", 64'(if2.in_ready), 64'(1));
        rst_n = 1'b1;
        step();

        // ---- expand pass from the vector table, full throughput ----
        begin_pass();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = tbl[k].d;
            step();
            chk("tbl_en2",   64'(if2.wr_en),   64'(tbl[k].en2));
            chk("tbl_addr2", 64'(if2.wr_addr), 64'(tbl[k].addr2));
            chk("tbl_data2", 64'(if2.wr_data), lanes(2, 4'(tbl[k].en2), tbl[k].cj2, tbl[k].d));
            chk("tbl_en4",   64'(if4.wr_en),   64'(tbl[k].en4));
            chk("tbl_addr4", 64'(if4.wr_addr), 64'(tbl[k].addr4));
            chk("tbl_data4", if4.wr_data,      lanes(4, tbl[k].en4, tbl[k].cj4, tbl[k].d));
        end
        in_valid = 1'b0;
        step();
        chk("done_not_yet", 64'(if2.done), 64'(0));
        chk("busy_in_drain", 64'(if2.busy), 64'(1));
        step();
        chk("done_pulse2", 64'(if2.done), 64'(1));
        chk("done_pulse4", 64'(if4.done), 64'(1));
        chk("busy_low_with_done", 64'(if2.busy), 64'(0));
        step();
        chk("done_one_cycle", 64'(if2.done), 64'(0));

        // ---- direct mode write to slot 6 ----
        d_base = n_done_obs;
        mode = 1'b0; in_valid = 1'b1; in_addr = 3'd6; in_data = 16'hABCD;
        step();
        in_valid = 1'b0;
        chk("direct_en4",   64'(if4.wr_en),   64'(4'b0100));
        chk("direct_addr4", 64'(if4.wr_addr), 64'(4'b0100));
        chk("direct_data4", if4.wr_data,      64'h0000_ABCD_0000_0000);
        step(); step(); step();
        chk("direct_no_done", 64'(n_done_obs - d_base), 64'(0));

        // ---- back-pressure: wr_ready low for 3 cycles after first accept ----
        a_base = n_acc_obs; r_base = n_ret_obs;
        begin_pass();
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_data = 16'h2222;
        snap_en = if2.wr_en; snap_addr = if2.wr_addr; snap_data = if2.wr_data;
        wr_ready = 1'b0;
        #1;
        chk("stall_in_ready2", 64'(if2.in_ready), 64'(0));
        chk("stall_in_ready4", 64'(if4.in_ready), 64'(0));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_en_hold",   64'(if2.wr_en),   64'(snap_en));
            chk("stall_addr_hold", 64'(if2.wr_addr), 64'(snap_addr));
            chk("stall_data_hold", 64'(if2.wr_data), 64'(snap_data));
        end
        wr_ready = 1'b1;
        step();
        in_valid = 1'b0;
        push(16'h3333);
        push(16'h4444);
        drain();
        chk("stall_accepts", 64'(n_acc_obs - a_base), 64'(4));
        chk("stall_retires", 64'(n_ret_obs - r_base), 64'(4));

        // ---- reset in the middle of a pass ----
        d_base = n_done_obs;
        begin_pass();
        push(16'h0101);
        push(16'h0202);
        rst_n = 1'b0;
        step();
        chk("midrst_en2",   64'(if2.wr_en),   64'(0));
        chk("midrst_addr2", 64'(if2.wr_addr), 64'(0));
        chk("midrst_data4", if4.wr_data,      64'(0));
        chk("midrst_busy",  64'(if2.busy),    64'(0));
        step();
        rst_n = 1'b1;
        step(); step();
        chk("midrst_no_done", 64'(n_done_obs - d_base), 64'(0));
        begin_pass();
        push(16'hC0DE);
        chk("restart_addr2", 64'(if2.wr_addr), 64'(4'b1100));
        chk("restart_data2", 64'(if2.wr_data), 64'(32'hC05E_C0DE));
        push(16'h0303); push(16'h0404); push(16'h0505);
        drain();

        // ---- start held and mode toggled during RUN ----
        a_base = n_acc_obs; d_base = n_done_obs;
        begin_pass();
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (n_acc_obs - a_base >= 4) break;
            start = 1'b1; mode = ~mode; in_data = 16'($urandom);
            step();
        end
        start = 1'b0; mode = 1'b1; in_valid = 1'b0;
        for (int t = 0; t < 8; t++) step();
        chk("toggle_accepts", 64'(n_acc_obs - a_base), 64'(4));
        chk("toggle_dones",   64'(n_done_obs - d_base), 64'(1));

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = 3'($urandom);
            in_data  = 16'($urandom);
            wr_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
